// File: rtl/operand_matcher_stream.sv
// -----------------------------------------------------------------------------
// operand_matcher_stream
//
// Purpose:
//   Accepts a weight/activation bitmask pair, forms the mutual (AND) mask and
//   streams out the matched operand index pairs in ascending bit position.
//   Each pair is (dense index into compressed A, dense index into compressed W)
//   where the dense index of bit p is the popcount of the mask below p.
//   Pairs leave in beats of up to LANES pairs. The final beat of a mask pair
//   carries last=1 and the total pair count.
//
// Ports:
//   clock      - single clock
//   resetn     - asynchronous, active-low reset
//   ivalid     - input mask pair valid
//   oready     - block can accept a mask pair
//   bitmaskW   - weight bitmask (L bits)
//   bitmaskA   - activation bitmask (L bits)
//   ovalid     - output beat valid
//   iready     - downstream accepts the beat
//   indicesA   - activation dense indices, lane k at [k*IDX +: IDX]
//   indicesW   - weight dense indices, same lane layout
//   numPairs   - number of valid lanes (0..numPairs-1) in the beat
//   last       - final beat of the current mask pair
//   totalPairs - popcount(A & W), non-zero only on the last beat
// -----------------------------------------------------------------------------
module operand_matcher_stream #(
    parameter int BITMASK_LENGTH       = 16,
    parameter int INDEX_BITWIDTH       = 4,
    parameter int LANES                = 4,
    parameter int LANE_COUNT_BITWIDTH  = 3,
    parameter int TOTAL_COUNT_BITWIDTH = 5
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic                                ivalid,
    output logic                                oready,
    input  logic [BITMASK_LENGTH-1:0]           bitmaskW,
    input  logic [BITMASK_LENGTH-1:0]           bitmaskA,
    output logic                                ovalid,
    input  logic                                iready,
    output logic [LANES*INDEX_BITWIDTH-1:0]     indicesA,
    output logic [LANES*INDEX_BITWIDTH-1:0]     indicesW,
    output logic [LANE_COUNT_BITWIDTH-1:0]      numPairs,
    output logic                                last,
    output logic [TOTAL_COUNT_BITWIDTH-1:0]     totalPairs
);

    localparam int L   = BITMASK_LENGTH;
    localparam int IDX = INDEX_BITWIDTH;
    localparam int LC  = LANE_COUNT_BITWIDTH;
    localparam int TC  = TOTAL_COUNT_BITWIDTH;

    // LANES <= L, so it always fits in the total-count width.
    localparam logic [TC-1:0] LANES_T = TC'(LANES);
    localparam logic [LC-1:0] LANES_C = LC'(LANES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state_q,     state_d;
    logic                   ready_en_q,  ready_en_d;
    logic [L-1:0]           mask_a_q,    mask_a_d;
    logic [L-1:0]           mask_w_q,    mask_w_d;
    logic [L-1:0]           remaining_q, remaining_d;
    logic                   ovalid_q,    ovalid_d;
    logic [LANES*IDX-1:0]   idx_a_q,     idx_a_d;
    logic [LANES*IDX-1:0]   idx_w_q,     idx_w_d;
    logic [LC-1:0]          num_q,       num_d;
    logic                   last_q,      last_d;
    logic [TC-1:0]          total_q,     total_d;

    // -------------------------------------------------------------------------
    // Prefix popcounts over the registered masks.
    // pre_a[p] / pre_w[p] are the dense indices of bit p; the largest is L-1,
    // so INDEX_BITWIDTH is enough. pre_r[p] is the rank of bit p among the
    // still-unsent mutual bits; pre_r[L] is how many are left.
    // -------------------------------------------------------------------------
    logic [IDX-1:0] pre_a [L];
    logic [IDX-1:0] pre_w [L];
    logic [TC-1:0]  pre_r [L+1];
    logic [L-1:0]   sel_mask;

    assign pre_r[0] = '0;

    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_prefix
            if (gi == 0) begin : g_first
                assign pre_a[gi] = '0;
                assign pre_w[gi] = '0;
            end else begin : g_rest
                assign pre_a[gi] = pre_a[gi-1] + {{(IDX-1){1'b0}}, mask_a_q[gi-1]};
                assign pre_w[gi] = pre_w[gi-1] + {{(IDX-1){1'b0}}, mask_w_q[gi-1]};
            end
            assign pre_r[gi+1] = pre_r[gi] + {{(TC-1){1'b0}}, remaining_q[gi]};
            // The lowest LANES remaining bits are the ones with rank < LANES.
            assign sel_mask[gi] = remaining_q[gi] && (pre_r[gi] < LANES_T);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Lane steering: lane k takes the remaining bit whose rank equals k.
    // Lanes with no such bit stay at zero.
    // -------------------------------------------------------------------------
    logic [LANES*IDX-1:0] beat_a;
    logic [LANES*IDX-1:0] beat_w;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [TC-1:0] LANE_RANK = TC'(gi);
            logic [IDX-1:0] lane_a;
            logic [IDX-1:0] lane_w;

            always_comb begin
                lane_a = '0;
                lane_w = '0;
                for (int p = 0; p < L; p++) begin
                    if (remaining_q[p] && (pre_r[p] == LANE_RANK)) begin
                        lane_a = pre_a[p];
                        lane_w = pre_w[p];
                    end
                end
            end

            assign beat_a[gi*IDX +: IDX] = lane_a;
            assign beat_w[gi*IDX +: IDX] = lane_w;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Beat size and total pair count
    // -------------------------------------------------------------------------
    function automatic logic [TC-1:0] popcount(input logic [L-1:0] v);
        logic [TC-1:0] c;
        c = '0;
        for (int i = 0; i < L; i++) begin
            c = c + {{(TC-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [LC-1:0] beat_num;
    logic [L-1:0]  remaining_after;
    logic [TC-1:0] total_calc;

    assign beat_num        = (pre_r[L] > LANES_T) ? LANES_C : LC'(pre_r[L]);
    assign remaining_after = remaining_q & ~sel_mask;
    assign total_calc      = popcount(mask_a_q & mask_w_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic accept;
    logic out_free;

    // ready_en_q keeps oready low during reset and through the first edge
    // after release, independent of the FSM state.
    assign oready   = (state_q == S_IDLE) && ready_en_q;
    assign accept   = ivalid && oready;
    assign out_free = !ovalid_q || iready;

    always_comb begin
        state_d     = state_q;
        ready_en_d  = 1'b1;
        mask_a_d    = mask_a_q;
        mask_w_d    = mask_w_q;
        remaining_d = remaining_q;
        ovalid_d    = ovalid_q;
        idx_a_d     = idx_a_q;
        idx_w_d     = idx_w_q;
        num_d       = num_q;
        last_d      = last_q;
        total_d     = total_q;

        // A consumed beat empties the output register; a new load below
        // overrides this in the same cycle.
        if (ovalid_q && iready) begin
            ovalid_d = 1'b0;
            idx_a_d  = '0;
            idx_w_d  = '0;
            num_d    = '0;
            last_d   = 1'b0;
            total_d  = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mask_a_d    = bitmaskA;
                    mask_w_d    = bitmaskW;
                    remaining_d = bitmaskA & bitmaskW;
                    state_d     = S_EMIT;
                end
            end

            S_EMIT: begin
                // An empty mutual mask still produces one (empty) last beat.
                if (out_free) begin
                    ovalid_d    = 1'b1;
                    idx_a_d     = beat_a;
                    idx_w_d     = beat_w;
                    num_d       = beat_num;
                    remaining_d = remaining_after;
                    if (remaining_after == '0) begin
                        last_d  = 1'b1;
                        total_d = total_calc;
                        state_d = S_IDLE;
                    end else begin
                        last_d  = 1'b0;
                        total_d = '0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            ready_en_q  <= 1'b0;
            mask_a_q    <= '0;
            mask_w_q    <= '0;
            remaining_q <= '0;
            ovalid_q    <= 1'b0;
            idx_a_q     <= '0;
            idx_w_q     <= '0;
            num_q       <= '0;
            last_q      <= 1'b0;
            total_q     <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= ready_en_d;
            mask_a_q    <= mask_a_d;
            mask_w_q    <= mask_w_d;
            remaining_q <= remaining_d;
            ovalid_q    <= ovalid_d;
            idx_a_q     <= idx_a_d;
            idx_w_q     <= idx_w_d;
            num_q       <= num_d;
            last_q      <= last_d;
            total_q     <= total_d;
        end
    end

    assign ovalid     = ovalid_q;
    assign indicesA   = idx_a_q;
    assign indicesW   = idx_w_q;
    assign numPairs   = num_q;
    assign last       = last_q;
    assign totalPairs = total_q;

endmodule

// File: tb/tb_operand_matcher_stream.sv
// -----------------------------------------------------------------------------
// tb_operand_matcher_stream
//
// Directed, table-driven bench for operand_matcher_stream at L=16, LANES=4.
// Table entries are expected beats; an entry flagged 'first' also supplies a
// new mask pair. Hand-written sequences cover backpressure with a queued mask
// and an asynchronous reset in the middle of a mask.
// -----------------------------------------------------------------------------
module tb_operand_matcher_stream;

    localparam int L   = 16;
    localparam int IDX = 4;
    localparam int LN  = 4;
    localparam int LC  = 3;
    localparam int TC  = 5;

    logic              clock;
    logic              resetn;
    logic              ivalid;
    logic              oready;
    logic [L-1:0]      bitmaskW;
    logic [L-1:0]      bitmaskA;
    logic              ovalid;
    logic              iready;
    logic [LN*IDX-1:0] indicesA;
    logic [LN*IDX-1:0] indicesW;
    logic [LC-1:0]     numPairs;
    logic              last;
    logic [TC-1:0]     totalPairs;

    int tests_run;
    int tests_failed;

    operand_matcher_stream #(
        .BITMASK_LENGTH      (L),
        .INDEX_BITWIDTH      (IDX),
        .LANES               (LN),
        .LANE_COUNT_BITWIDTH (LC),
        .TOTAL_COUNT_BITWIDTH(TC)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .ivalid    (ivalid),
        .oready    (oready),
        .bitmaskW  (bitmaskW),
        .bitmaskA  (bitmaskA),
        .ovalid    (ovalid),
        .iready    (iready),
        .indicesA  (indicesA),
        .indicesW  (indicesW),
        .numPairs  (numPairs),
        .last      (last),
        .totalPairs(totalPairs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic              first;
        logic [L-1:0]      a;
        logic [L-1:0]      w;
        logic [LN*IDX-1:0] ia;
        logic [LN*IDX-1:0] iw;
        logic [LC-1:0]     num;
        logic              lst;
        logic [TC-1:0]     total;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic f, input logic [15:0] a, input logic [15:0] w,
                                input logic [15:0] ia, input logic [15:0] iw,
                                input logic [2:0] num, input logic lst, input logic [4:0] total);
        vec_t v;
        v.first = f;
        v.a     = a;
        v.w     = w;
        v.ia    = ia;
        v.iw    = iw;
        v.num   = num;
        v.lst   = lst;
        v.total = total;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [15:0] ia, input logic [15:0] iw,
                              input logic [2:0] num, input logic lst, input logic [4:0] total,
                              input logic ordy);
        $display("[TB] beat %s: ovalid=%0b ia=%h iw=%h num=%0d last=%0b total=%0d oready=%0b",
                 tag, ovalid, indicesA, indicesW, numPairs, last, totalPairs, oready);
        check({tag, "_ovalid"}, 32'(ovalid),     32'd1);
        check({tag, "_ia"},     32'(indicesA),   32'(ia));
        check({tag, "_iw"},     32'(indicesW),   32'(iw));
        check({tag, "_num"},    32'(numPairs),   32'(num));
        check({tag, "_last"},   32'(last),       32'(lst));
        check({tag, "_total"},  32'(totalPairs), 32'(total));
        check({tag, "_oready"}, 32'(oready),     32'(ordy));
    endtask

    // Safety net: the main sequence finishes far earlier than this.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required $finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        ivalid       = 1'b0;
        iready       = 1'b1;
        bitmaskA     = '0;
        bitmaskW     = '0;

        // Expected beats, hand-computed (lane k at [4k+:4]).
        vecs[0] = mk(1'b1, 16'hFFFF, 16'hFFFF, 16'h3210, 16'h3210, 3'd4, 1'b0, 5'd0);
        vecs[1] = mk(1'b0, 16'hFFFF, 16'hFFFF, 16'h7654, 16'h7654, 3'd4, 1'b0, 5'd0);
        vecs[2] = mk(1'b0, 16'hFFFF, 16'hFFFF, 16'hBA98, 16'hBA98, 3'd4, 1'b0, 5'd0);
        vecs[3] = mk(1'b0, 16'hFFFF, 16'hFFFF, 16'hFEDC, 16'hFEDC, 3'd4, 1'b1, 5'd16);
        vecs[4] = mk(1'b1, 16'hAAAA, 16'hFF00, 16'h7654, 16'h7531, 3'd4, 1'b1, 5'd4);
        vecs[5] = mk(1'b1, 16'h00FF, 16'hFF00, 16'h0000, 16'h0000, 3'd0, 1'b1, 5'd0);
        vecs[6] = mk(1'b1, 16'h003F, 16'h003F, 16'h3210, 16'h3210, 3'd4, 1'b0, 5'd0);
        vecs[7] = mk(1'b0, 16'h003F, 16'h003F, 16'h0054, 16'h0054, 3'd2, 1'b1, 5'd6);
        vecs[8] = mk(1'b1, 16'h8001, 16'hFFFF, 16'h0010, 16'h00F0, 3'd2, 1'b1, 5'd2);
        vecs[9] = mk(1'b1, 16'hFFFF, 16'h8000, 16'h000F, 16'h0000, 3'd1, 1'b1, 5'd1);

        // ---------------- reset state ----------------
        #12;
        check("rst_ovalid", 32'(ovalid),   32'd0);
        check("rst_oready", 32'(oready),   32'd0);
        check("rst_num",    32'(numPairs), 32'd0);
        check("rst_ia",     32'(indicesA), 32'd0);
        check("rst_last",   32'(last),     32'd0);
        #10;
        resetn = 1'b1;
        #1;
        check("rst_release_oready", 32'(oready), 32'd0);
        step();
        check("rst_first_edge_oready", 32'(oready), 32'd1);

        // ---------------- table-driven masks, iready=1 ----------------
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].first) begin
                check($sformatf("v%0d_oready_idle", i), 32'(oready), 32'd1);
                bitmaskA = vecs[i].a;
                bitmaskW = vecs[i].w;
                ivalid   = 1'b1;
                step();
                ivalid   = 1'b0;
                check($sformatf("v%0d_accept_ovalid", i), 32'(ovalid), 32'd0);
            end
            step();
            check_beat($sformatf("v%0d", i), vecs[i].ia, vecs[i].iw, vecs[i].num,
                       vecs[i].lst, vecs[i].total, vecs[i].lst);
        end
        step();
        check("table_drain_ovalid", 32'(ovalid),   32'd0);
        check("table_drain_num",    32'(numPairs), 32'd0);

        // ---------------- backpressure with a queued second mask ----------------
        bitmaskA = 16'hFFFF;
        bitmaskW = 16'hFFFF;
        ivalid   = 1'b1;
        step();
        ivalid   = 1'b0;
        step();
        check_beat("s_b0", 16'h3210, 16'h3210, 3'd4, 1'b0, 5'd0, 1'b0);
        step();
        check_beat("s_b1", 16'h7654, 16'h7654, 3'd4, 1'b0, 5'd0, 1'b0);
        iready   = 1'b0;
        ivalid   = 1'b1;
        bitmaskA = 16'h003F;
        bitmaskW = 16'h003F;
        for (int c = 0; c < 3; c++) begin
            step();
            check_beat($sformatf("s_b1_hold%0d", c), 16'h7654, 16'h7654, 3'd4, 1'b0, 5'd0, 1'b0);
        end
        iready = 1'b1;
        step();
        check_beat("s_b2", 16'hBA98, 16'hBA98, 3'd4, 1'b0, 5'd0, 1'b0);
        step();
        check_beat("s_b3", 16'hFEDC, 16'hFEDC, 3'd4, 1'b1, 5'd16, 1'b1);
        iready = 1'b0;
        step();                      // second mask accepted, beat3 still held
        ivalid = 1'b0;
        check_beat("s_b3_hold0", 16'hFEDC, 16'hFEDC, 3'd4, 1'b1, 5'd16, 1'b0);
        step();
        check_beat("s_b3_hold1", 16'hFEDC, 16'hFEDC, 3'd4, 1'b1, 5'd16, 1'b0);
        iready = 1'b1;
        step();
        check_beat("s_m2_b0", 16'h3210, 16'h3210, 3'd4, 1'b0, 5'd0, 1'b0);
        step();
        check_beat("s_m2_b1", 16'h0054, 16'h0054, 3'd2, 1'b1, 5'd6, 1'b1);
        step();
        check("s_drain_ovalid", 32'(ovalid), 32'd0);

        // ---------------- asynchronous reset mid-mask ----------------
        bitmaskA = 16'hFFFF;
        bitmaskW = 16'hFFFF;
        ivalid   = 1'b1;
        step();
        ivalid   = 1'b0;
        step();
        step();
        check_beat("r_b1", 16'h7654, 16'h7654, 3'd4, 1'b0, 5'd0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        $display("[TB] async reset asserted: ovalid=%0b num=%0d last=%0b", ovalid, numPairs, last);
        check("r_async_ovalid", 32'(ovalid),   32'd0);
        check("r_async_num",    32'(numPairs), 32'd0);
        check("r_async_last",   32'(last),     32'd0);
        check("r_async_oready", 32'(oready),   32'd0);
        check("r_async_ia",     32'(indicesA), 32'd0);
        step();
        #2;
        resetn = 1'b1;
        #1;
        check("r_release_oready", 32'(oready), 32'd0);
        step();
        check("r_post_oready", 32'(oready), 32'd1);
        check("r_post_ovalid", 32'(ovalid), 32'd0);
        bitmaskA = 16'h0001;
        bitmaskW = 16'h0001;
        ivalid   = 1'b1;
        step();
        ivalid   = 1'b0;
        step();
        check_beat("r_single", 16'h0000, 16'h0000, 3'd1, 1'b1, 5'd1, 1'b1);
        step();
        check("r_single_drain_ovalid", 32'(ovalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/operand_matcher_stream.md
Name: operand_matcher_stream

Overview:
- Parametrised, streaming successor to the 8-bit operand matcher. Takes a weight/activation bitmask pair, forms the mutual (AND) mask, and emits matched index pairs.
- Each pair is (dense index into compressed A, dense index into compressed W), in ascending bit position. Pairs go out as beats of up to LANES pairs, with valid/ready handshakes on both sides.
- Sits between the sparse-tensor bitmask fetch and the PE operand-gather stage.

Parameters:
- BITMASK_LENGTH, 16, mask width L; power of 2, >= 4.
- INDEX_BITWIDTH, 4, width of one index; equals clog2(L).
- LANES, 4, max pairs per output beat; 1..L.
- LANE_COUNT_BITWIDTH, 3, clog2(LANES+1).
- TOTAL_COUNT_BITWIDTH, 5, clog2(L+1).

Ports:
- clock  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- ivalid  in  1  input mask pair valid.
- oready  out  1  block can accept a mask pair.
- bitmaskW  in  L  weight bitmask.
- bitmaskA  in  L  activation bitmask.
- ovalid  out  1  output beat valid.
- iready  in  1  downstream accepts beat.
- indicesA  out  LANES*INDEX_BITWIDTH  lane k at [k*IDX +: IDX]; activation dense indices.
- indicesW  out  LANES*INDEX_BITWIDTH  weight dense indices, same lane layout.
- numPairs  out  LANE_COUNT_BITWIDTH  valid lanes in beat; lanes 0..numPairs-1 are valid.
- last  out  1  final beat of current mask pair.
- totalPairs  out  TOTAL_COUNT_BITWIDTH  popcount(A&W); valid only when last=1, else 0.

Behaviour:
- Reset:
  - Asynchronous on resetn low: state=IDLE, all registers cleared.
  - ovalid=0, oready=0 while resetn low; all data outputs 0.
  - oready rises the first clock edge after release.
  - Reset mid-operation discards the in-flight mask and any held beat.
- Index definition: for mutual bit position p (bit 0 is first):
  - A index = popcount(bitmaskA[p-1:0]); W index = popcount(bitmaskW[p-1:0]).
  - Position 0 gives index 0.
- FSM IDLE:
  - oready=1.
  - On ivalid&&oready at an edge: register bitmaskA, bitmaskW, remaining=A&W; go to EMIT.
- FSM EMIT:
  - oready=0.
  - Each cycle where the output register is free (!ovalid || iready), load one beat: the lowest min(LANES, popcount(remaining)) set bits of remaining, in ascending order, into lanes 0..n-1.
  - Clear those bits from remaining.
  - If remaining becomes 0, set last=1, load totalPairs, and return to IDLE.
- Empty mutual mask: exactly one beat with numPairs=0, last=1, totalPairs=0, all indices 0.
- Unused lanes (k >= numPairs) drive 0.
- Output register holds stably while ovalid && !iready; no beat is dropped or duplicated.
- ovalid drops after a beat is consumed with no new beat loaded.
- Latency: acceptance edge E0 → first beat registered at E1 → ovalid high after E1.
- Throughput with iready=1:
  - One beat per cycle within a mask.
  - A new mask is accepted the cycle after the last beat loads, so single-beat masks sustain one mask per 2 cycles.
- The last beat may still be held (waiting on iready) while the next mask is accepted. The next mask's first beat loads only once the held beat is consumed.
- Arithmetic:
  - Prefix counts are computed at INDEX_BITWIDTH and cannot overflow, since max index is L-1.
  - Counts are computed from the registered masks, not the live inputs.
- ivalid while oready=0 is ignored; the upstream holds its data.

Test Plan:
- L=16, LANES=4, A=W=16'hFFFF, iready=1 → 4 consecutive beats, numPairs=4 each.
  - Beat b lane k: indicesA=indicesW=4b+k.
  - last on beat 3 only, with totalPairs=16.
- A=16'hAAAA, W=16'hFF00 → one beat, numPairs=4, last=1, totalPairs=4.
  - indicesA lanes0-3 = 4,5,6,7.
  - indicesW lanes0-3 = 1,3,5,7.
- A=16'h00FF, W=16'hFF00 → one beat, numPairs=0, last=1, totalPairs=0, all indices 0; oready back high the next cycle.
- A=W=16'h003F → beat0 pairs 0..3 (numPairs=4, last=0); beat1 lanes0-1 = 4,5, lanes2-3 = 0, numPairs=2, last=1, totalPairs=6.
- Repeat the A=W=16'hFFFF case with iready low for 3 cycles on beat1, and ivalid held high with a second mask pair:
  - beat1 is held unchanged and no beat is lost.
  - oready stays 0 until the last beat loads.
  - The second mask's first beat appears only after beat3 is consumed.
- Drop resetn mid-EMIT after beat1 → ovalid, numPairs, last go 0 immediately, with no clock needed.
  - After release, a mask A=W=16'h0001 yields a single beat: lane0 indices 0/0, numPairs=1, last=1.
